// File: rtl/usb_rx_deframer.sv
// Full-speed USB receive deframer: sync, bit timing, NRZI decode,
// bit unstuffing, SYNC check and byte delivery with framing status.
module usb_rx_deframer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       eop,
  output logic       d_plus_sync,
  output logic       d_minus_sync,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_packet_done,
  output logic       rx_error,
  output logic       rx_active
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RECEIVE,
    EOP_WAIT,
    ERROR
  } state_t;

  state_t        state;
  logic          dp_meta;
  logic          dm_meta;
  logic          dp_prev;
  logic          prev_bit;
  logic          seen_eop;
  logic [TW-1:0] timer;
  logic [7:0]    shreg;
  logic [2:0]    cnt;
  logic [2:0]    ones;
  logic          edge_det;
  logic          fall;
  logic          sample;
  logic          bit_val;
  logic [7:0]    next_byte;

  assign edge_det  = d_plus_sync ^ dp_prev;
  assign fall      = dp_prev & ~d_plus_sync;
  assign sample    = timer == TW'(SAMPLE_POINT);
  assign bit_val   = d_plus_sync == prev_bit;
  assign next_byte = {bit_val, shreg[7:1]};

  // Lines reset to idle J
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta      <= 1'b1;
      d_plus_sync  <= 1'b1;
      dm_meta      <= 1'b0;
      d_minus_sync <= 1'b0;
      dp_prev      <= 1'b1;
    end else begin
      dp_meta      <= d_plus;
      d_plus_sync  <= dp_meta;
      dm_meta      <= d_minus;
      d_minus_sync <= dm_meta;
      dp_prev      <= d_plus_sync;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer <= '0;
    end else if (state == IDLE && fall) begin
      timer <= '0;
    end else if (rx_active && edge_det) begin
      timer <= '0;
    end else if (timer == TW'(CLKS_PER_BIT - 1)) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      rx_data        <= 8'h00;
      rx_data_valid  <= 1'b0;
      rx_packet_done <= 1'b0;
      rx_error       <= 1'b0;
      rx_active      <= 1'b0;
      shreg          <= 8'h00;
      cnt            <= 3'd0;
      ones           <= 3'd0;
      prev_bit       <= 1'b1;
      seen_eop       <= 1'b0;
    end else begin
      rx_data_valid  <= 1'b0;
      rx_packet_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state     <= SYNC;
            rx_active <= 1'b1;
            rx_error  <= 1'b0;
            shreg     <= 8'h00;
            cnt       <= 3'd0;
            ones      <= 3'd0;
            prev_bit  <= 1'b1;
            seen_eop  <= 1'b0;
          end
        end
        SYNC, RECEIVE: begin
          if (sample) begin
            prev_bit <= d_plus_sync;
            // eop outranks any stuff check on the same sample
            if (eop) begin
              if (state == RECEIVE && cnt == 3'd0) begin
                state <= EOP_WAIT;
              end else begin
                state    <= ERROR;
                rx_error <= 1'b1;
                seen_eop <= 1'b1;
              end
            end else if (ones == 3'd6) begin
              if (bit_val) begin
                state    <= ERROR;
                rx_error <= 1'b1;
              end else begin
                ones <= 3'd0;
              end
            end else begin
              ones  <= bit_val ? ones + 3'd1 : 3'd0;
              shreg <= next_byte;
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                if (state == SYNC) begin
                  if (next_byte == 8'h80) begin
                    state <= RECEIVE;
                  end else begin
                    state    <= ERROR;
                    rx_error <= 1'b1;
                  end
                end else begin
                  rx_data       <= next_byte;
                  rx_data_valid <= 1'b1;
                end
              end
            end
          end
        end
        EOP_WAIT: begin
          if (sample && !eop) begin
            if (d_plus_sync) begin
              state          <= IDLE;
              rx_active      <= 1'b0;
              rx_packet_done <= 1'b1;
            end else begin
              state    <= ERROR;
              rx_error <= 1'b1;
            end
          end
        end
        ERROR: begin
          // leave only on an SE0 sample followed directly by a J sample
          if (sample) begin
            if (eop) begin
              seen_eop <= 1'b1;
            end else if (seen_eop && d_plus_sync) begin
              state     <= IDLE;
              rx_active <= 1'b0;
              seen_eop  <= 1'b0;
            end else begin
              seen_eop <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
